adc_avg_bcd: RTL and testbench
==============================

# adc_avg_bcd

Post-processing stage that sits directly downstream of `adcinterface`. It takes each 12-bit LTC2308 conversion result, block-averages 2^AVG_LOG2 samples of the selected channel, and converts the average to four packed BCD digits with a sequential shift-add-3 (double-dabble) engine. The 7-segment digit mux displays the result as millivolts: 4.096 V reference, 1 LSB = 1 mV.

## Interface

**Parameters**
- `AVG_LOG2`, default 3: log2 of samples per average. Legal range 0..6; 0 means every sample is converted.

**Ports**
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `result_valid`  input  1  one-cycle strobe; `result` is valid in this cycle.
- `result`  input  12  unsigned ADC code, 0..4095.
- `chan`  input  3  currently selected ADC channel. Level, may change at any cycle.
- `bcd`  output  16  {thousands, hundreds, tens, ones}, each 4 bits. Registered.
- `bcd_valid`  output  1  one-cycle pulse when `bcd` has just been updated.
- `busy`  output  1  high while the BCD engine is converting.

## Operation

**Reset**
- Outputs: `bcd`=16'h0000, `bcd_valid`=0, `busy`=0.
- Internal state: accumulator=0, sample count=0, `chan_q`=`chan`, discard flag=1.

**Discard rule**
- The LTC2308 returns the previous conversion, so the first `result_valid` after reset, or after any change of `chan`, is dropped. Dropping it clears the discard flag.

**Channel change**
- Trigger: `chan` != `chan_q` in any cycle.
- Actions in that cycle: accumulator and count clear to 0, discard flag sets, `chan_q` updates.
- A conversion in progress is aborted. `busy` drops, `bcd` is held, and no `bcd_valid` pulse is produced.
- A `result_valid` in the same cycle is ignored.

**Accumulate**
- On a `result_valid` that is not discarded: acc += `result` (width 12+AVG_LOG2, cannot overflow) and count += 1.
- When the count reaches 2^AVG_LOG2:
  - avg = (acc + `result`) >> AVG_LOG2, truncating.
  - acc and count clear in the same cycle.
  - avg is handed to the engine.

**BCD engine** (states IDLE and CONVERT)
- IDLE → CONVERT on handoff. Load a 28-bit shift register as {16'h0, avg}, set iteration=0, and set `busy`=1.
- CONVERT, each cycle:
  - In the upper 16 bits, add 3 to every nibble that is ≥5.
  - Then shift the whole register left by 1.
  - Increment iteration.
- After the 12th shift:
  - `bcd` ← upper 16 bits.
  - Pulse `bcd_valid` for one cycle.
  - Return to IDLE, `busy`=0.
- A handoff while in CONVERT is discarded. The engine is not restarted and accumulation continues normally.

**Value bounds**
- Maximum output is 16'h4095.
- Each digit must always be 0..9.

## Timing

- Let T be the cycle in which the completing `result_valid` is sampled.
  - `busy` goes high in cycle T+1.
  - The shifts occur at the edges ending cycles T+1..T+12.
  - `bcd` changes and `bcd_valid`=1 in cycle T+13; `busy`=0 in cycle T+13.
  - Latency is 13 cycles, independent of AVG_LOG2.
- Minimum spacing between completing strobes for a lossless stream is 13 cycles. In the system the ADC strobes arrive roughly every 2^16 cycles.
- `bcd` is stable between pulses and never shows a partial conversion.
- Reset asserted mid-CONVERT: next cycle `bcd`=0, `busy`=0, and no pulse follows.
- `reset` overrides channel change and `result_valid` in the same cycle.
- With AVG_LOG2=0, every non-discarded strobe starts a conversion, subject to the busy-drop rule.

## Test plan

- **Basic average.** AVG_LOG2=3. After reset, send 9 strobes of 1234, spaced 20 cycles. Required: the first strobe is discarded; exactly one `bcd_valid` occurs, 13 cycles after the 9th strobe, with `bcd`=16'h1234.
- **Truncation.** After the discard strobe, send samples 0..7 (sum 28). Required: `bcd`=16'h0003. Then send 8×4095: `bcd`=16'h4095. Then send 8×0: `bcd`=16'h0000.
- **Channel change.** Send 4 valid samples of 500, then change `chan` 0→2 together with a strobe. Then send 1 strobe of 999 followed by 8 strobes of 2000. Required: the 999 is discarded and the single output is 16'h2000.
- **Reset mid-conversion.** Assert `reset` 5 cycles after a completing strobe. Required: `bcd`=0, `busy`=0, and no `bcd_valid` pulse for 20 cycles.
- **Busy drop.** AVG_LOG2=0. Send strobes of 100 and 200 spaced 4 cycles apart (after the discard strobe). Required: one pulse with `bcd`=16'h0100 and no second pulse.
- **Random sweep.** 1000 random samples with random spacing of 13..40 cycles and AVG_LOG2=2. Required: each pulse matches a reference model of floor(sum/4) to BCD, and every digit is ≤9.

Source files
------------

// File: rtl/adc_avg_bcd.sv
// Block-averages 2^AVG_LOG2 ADC samples of the selected channel and converts the
// average to four packed BCD digits with a sequential shift-add-3 engine.
module adc_avg_bcd #(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        result_valid,
  input  logic [11:0] result,
  input  logic [2:0]  chan,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        busy
);

  localparam int unsigned AccW = 12 + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d, sum;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            discard_q, discard_d;
  logic [2:0]      chan_q, chan_d;
  logic [27:0]     sr_q, sr_d, sr_adj, sr_shift;
  logic [3:0]      iter_q, iter_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            bcd_valid_q, bcd_valid_d;
  logic            handoff;
  logic [11:0]     avg;

  // Sum cannot overflow: 2^AVG_LOG2 * 4095 < 2^(12+AVG_LOG2).
  assign sum = acc_q + AccW'(result);
  assign avg = sum[AccW-1:AVG_LOG2];

  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[12+4*i +: 4] >= 4'd5) begin
        sr_adj[12+4*i +: 4] = sr_q[12+4*i +: 4] + 4'd3;
      end
    end
  end

  assign sr_shift = sr_adj << 1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    chan_d      = chan_q;
    sr_d        = sr_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    handoff     = 1'b0;

    if (chan != chan_q) begin
      // Channel switch restarts averaging and aborts any conversion; bcd is held.
      chan_d    = chan;
      acc_d     = '0;
      cnt_d     = '0;
      discard_d = 1'b1;
      state_d   = StIdle;
    end else begin
      if (result_valid) begin
        if (discard_q) begin
          discard_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          acc_d   = '0;
          cnt_d   = '0;
          handoff = 1'b1;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CntW'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (handoff) begin
            state_d = StConvert;
            sr_d    = {16'h0000, avg};
            iter_d  = 4'd0;
          end
        end
        StConvert: begin
          sr_d   = sr_shift;
          iter_d = iter_q + 4'd1;
          if (iter_q == 4'd11) begin
            bcd_d       = sr_shift[27:12];
            bcd_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b1;
      chan_q      <= chan;
      sr_q        <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      chan_q      <= chan_d;
      sr_q        <= sr_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q == StConvert);

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Drives three adc_avg_bcd instances (AVG_LOG2 = 3, 0, 2) with shared stimulus and
// checks them every cycle against an arithmetic model of averaging and decimal digits.
module tb_adc_avg_bcd;

  logic        clk;
  logic        reset;
  logic        result_valid;
  logic [11:0] result;
  logic [2:0]  chan;

  logic [15:0] bcd_a, bcd_b, bcd_c;
  logic        bv_a, bv_b, bv_c;
  logic        busy_a, busy_b, busy_c;

  adc_avg_bcd #(.AVG_LOG2(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result(result), .chan(chan),
    .bcd(bcd_a), .bcd_valid(bv_a), .busy(busy_a)
  );
  adc_avg_bcd #(.AVG_LOG2(0)) u_dut_l0 (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result(result), .chan(chan),
    .bcd(bcd_b), .bcd_valid(bv_b), .busy(busy_b)
  );
  adc_avg_bcd #(.AVG_LOG2(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result(result), .chan(chan),
    .bcd(bcd_c), .bcd_valid(bv_c), .busy(busy_c)
  );

  logic [17:0] obs [3];
  assign obs[0] = {bcd_a, bv_a, busy_a};
  assign obs[1] = {bcd_b, bv_b, busy_b};
  assign obs[2] = {bcd_c, bv_c, busy_c};

  int checks;
  int failures;
  int cyc;
  int lg [3];

  // Model state per instance
  bit          m_disc  [3];
  int          m_sum   [3];
  int          m_n     [3];
  bit          m_conv  [3];
  int          m_done  [3];
  int          m_pend  [3];
  logic [15:0] m_bcd   [3];
  bit          m_pulse [3];
  logic [2:0]  m_chq   [3];
  int          pulses  [3];
  int          lastp   [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] v, input int gap);
    result       = v;
    result_valid = 1'b1;
    idle(1);
    result_valid = 1'b0;
    idle(gap - 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // Compare outputs for the current cycle, then advance the model with this cycle's inputs.
  task automatic monitor();
    logic [17:0] e;
    bit          was;
    int          a;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        e = {m_bcd[k], m_pulse[k], m_conv[k]};
        checks++;
        if (obs[k] !== e) begin
          failures++;
          $display("FAIL cycle dut%0d cyc=%0d got bcd=%h valid=%b busy=%b exp bcd=%h valid=%b busy=%b",
                   k, cyc, obs[k][17:2], obs[k][1], obs[k][0], e[17:2], e[1], e[0]);
        end
        if (obs[k][1] === 1'b1) begin
          pulses[k]++;
          lastp[k] = cyc;
          checks++;
          if (obs[k][17:14] > 4'd9 || obs[k][13:10] > 4'd9 || obs[k][9:6] > 4'd9 ||
              obs[k][5:2] > 4'd9) begin
            failures++;
            $display("FAIL digits dut%0d got bcd=%h exp each digit <= 9", k, obs[k][17:2]);
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        m_pulse[k] = 1'b0;
        if (reset) begin
          m_bcd[k]  = '0;
          m_conv[k] = 1'b0;
          m_disc[k] = 1'b1;
          m_sum[k]  = 0;
          m_n[k]    = 0;
          m_chq[k]  = chan;
        end else if (chan !== m_chq[k]) begin
          m_chq[k]  = chan;
          m_sum[k]  = 0;
          m_n[k]    = 0;
          m_disc[k] = 1'b1;
          m_conv[k] = 1'b0;
        end else begin
          was = m_conv[k];
          if (m_conv[k] && cyc == m_done[k]) begin
            m_bcd[k]   = to_bcd(m_pend[k]);
            m_pulse[k] = 1'b1;
            m_conv[k]  = 1'b0;
          end
          if (result_valid) begin
            if (m_disc[k]) begin
              m_disc[k] = 1'b0;
            end else begin
              m_sum[k] += int'(result);
              m_n[k]++;
              if (m_n[k] == (1 << lg[k])) begin
                a        = m_sum[k] >> lg[k];
                m_sum[k] = 0;
                m_n[k]   = 0;
                if (!was) begin
                  m_conv[k] = 1'b1;
                  m_pend[k] = a;
                  m_done[k] = cyc + 12;
                end
              end
            end
          end
        end
      end
      cyc++;
    end
  endtask

  initial begin
    int base;
    int base0;
    int t;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    lg[0] = 3;
    lg[1] = 0;
    lg[2] = 2;
    for (int k = 0; k < 3; k++) begin
      m_disc[k]  = 1'b1;
      m_sum[k]   = 0;
      m_n[k]     = 0;
      m_conv[k]  = 1'b0;
      m_done[k]  = 0;
      m_pend[k]  = 0;
      m_bcd[k]   = '0;
      m_pulse[k] = 1'b0;
      m_chq[k]   = '0;
      pulses[k]  = 0;
      lastp[k]   = 0;
    end
    reset        = 1'b1;
    result_valid = 1'b0;
    result       = '0;
    chan         = '0;
    fork
      monitor();
    join_none

    idle(3);
    reset = 1'b0;
    check("reset_bcd", 32'(bcd_a), 32'h0);
    check("reset_valid", 32'(bv_a), 32'h0);
    check("reset_busy", 32'(busy_a), 32'h0);

    // Basic average: first strobe dropped, then 8 x 1234
    base = pulses[0];
    for (int i = 0; i < 8; i++) send(12'd1234, 20);
    t = cyc;
    send(12'd1234, 1);
    check("busy_rise", 32'(busy_a), 32'h1);
    idle(19);
    check("basic_pulses", 32'(pulses[0] - base), 32'd1);
    check("basic_latency", 32'(lastp[0]), 32'(t + 13));
    check("basic_bcd", 32'(bcd_a), 32'h1234);

    // Truncation and extremes
    do_reset();
    send(12'd0, 20);
    base = pulses[0];
    for (int i = 0; i < 8; i++) send(12'(i), 20);
    check("trunc_bcd", 32'(bcd_a), 32'h0003);
    for (int i = 0; i < 8; i++) send(12'd4095, 20);
    check("max_bcd", 32'(bcd_a), 32'h4095);
    for (int i = 0; i < 8; i++) send(12'd0, 20);
    check("zero_bcd", 32'(bcd_a), 32'h0000);
    check("trunc_pulses", 32'(pulses[0] - base), 32'd3);

    // Channel change mid-block
    do_reset();
    send(12'd0, 20);
    for (int i = 0; i < 4; i++) send(12'd500, 20);
    base = pulses[0];
    chan = 3'd2;
    send(12'd777, 20);
    send(12'd999, 20);
    for (int i = 0; i < 8; i++) send(12'd2000, 20);
    check("chan_pulses", 32'(pulses[0] - base), 32'd1);
    check("chan_bcd", 32'(bcd_a), 32'h2000);

    // Reset mid-conversion, starting from a non-zero display
    chan = 3'd0;
    idle(2);
    send(12'd0, 20);
    for (int i = 0; i < 7; i++) send(12'd1111, 20);
    send(12'd1111, 5);
    check("midconv_busy_before", 32'(busy_a), 32'h1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    base = pulses[0];
    check("midconv_bcd", 32'(bcd_a), 32'h0);
    check("midconv_busy", 32'(busy_a), 32'h0);
    idle(20);
    check("midconv_no_pulse", 32'(pulses[0] - base), 32'd0);
    check("midconv_bcd_hold", 32'(bcd_a), 32'h0);

    // Busy drop with AVG_LOG2 = 0
    do_reset();
    send(12'd0, 20);
    base = pulses[1];
    send(12'd100, 4);
    send(12'd200, 30);
    check("drop_pulses", 32'(pulses[1] - base), 32'd1);
    check("drop_bcd", 32'(bcd_b), 32'h0100);

    // Random sweep
    do_reset();
    base  = pulses[2];
    base0 = pulses[1];
    for (int i = 0; i < 1000; i++) begin
      send(12'($urandom_range(0, 4095)), int'($urandom_range(13, 40)));
    end
    idle(20);
    check("sweep_pulses_l2", 32'(pulses[2] - base), 32'd249);
    check("sweep_pulses_l0", 32'(pulses[1] - base0), 32'd999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
